fact_req_arbiter: RTL and testbench
===================================

Name: fact_req_arbiter

Overview:
- Shares one factorial accelerator (4-bit n in, Go, Done/Error, 32-bit product out) between NREQ independent requesters.
- Arbitrates round-robin and sequences each Go/Done transaction.
- Returns the result or error to the winning requester, tagged with its ID.
- Includes a watchdog timeout so a hung accelerator cannot lock out the requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must be at least clog2(NREQ).
- TIMEOUT, 64, maximum WAIT cycles before aborting the transaction.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST_n  in  1  synchronous, active-low reset.
- req  in  NREQ  request valid, one bit per requester; held until acked.
- req_n  in  4*NREQ  operand n for requester i, at bits [4i+3:4i].
- req_ack  out  NREQ  one-hot, one-cycle pulse when a request is captured.
- fa_n  out  4  operand to the accelerator.
- fa_go  out  1  start pulse to the accelerator.
- fa_done  in  1  accelerator result valid.
- fa_error  in  1  accelerator error (overflow, n>12).
- fa_product  in  32  accelerator result.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  IDW  requester the response belongs to.
- rsp_product  out  32  result; 0 when rsp_error=1.
- rsp_error  out  1  accelerator error or timeout.
- rsp_timeout  out  1  set only when the error cause is timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. RST_n=0 at a rising edge gives:
  - state=IDLE, rr_ptr=0, timer=0;
  - all outputs 0 (req_ack, fa_go, fa_n, rsp_*, busy).
- Reset mid-transaction aborts the transaction with no response; the in-flight requester is not re-served unless it re-requests.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, pick the winner by round-robin: the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch its ID and req_n slice, then go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE (exactly 1 cycle): fa_go=1, req_ack[id]=1, fa_n=latched n, busy=1. Next state is WAIT and timer is cleared.
- The requester must drop req in the cycle after its ack, or present a new request. A req still high in the next IDLE is treated as a new request.
- WAIT:
  - fa_go=0; fa_n is held stable; timer increments each cycle.
  - fa_done and fa_error are sampled every WAIT cycle. The accelerator clears Done/Error on the edge it samples Go.
  - If fa_error=1 (with or without fa_done): go to RESP with error=1, product=0, timeout=0.
  - Else if fa_done=1: go to RESP with error=0 and product=fa_product.
  - Else if timer==TIMEOUT-1: go to RESP with error=1, timeout=1, product=0.
- RESP (1 cycle): rsp_valid=1, rsp_id/rsp_product/rsp_error/rsp_timeout valid. rr_ptr becomes (id+1) mod NREQ. Next state is IDLE.
- rsp_* data fields hold their value until the next RESP; only rsp_valid is pulsed.
- Minimum request-to-response time is 4 cycles plus accelerator latency (IDLE sample, ISSUE, WAIT of at least 1 cycle, RESP).
- fa_done and fa_error are ignored outside WAIT.
- req changes outside IDLE are ignored; there is no preemption.
- Only one transaction is outstanding at a time.

Test Plan:
- Single request: requester 0 with n=3 → req_ack=4'b0001 for 1 cycle, one fa_go pulse with fa_n=3; rsp_valid with rsp_id=0, rsp_product=6, rsp_error=0.
- Boundary values: n=12 → rsp_product=479001600. n=13 → rsp_error=1, rsp_product=0, rsp_timeout=0. n=0 → rsp_product=1.
- Fairness: all 4 requesters hold req (n=1,2,3,4) and re-request after each ack.
  - Ack order must be 0,1,2,3,0.
  - Products must be 1,2,6,24.
  - No requester may be acked twice before the others.
- Timeout: accelerator stub never asserts done. After exactly TIMEOUT WAIT cycles → rsp_error=1, rsp_timeout=1, then back to IDLE. A subsequent n=5 request returns 120.
- Simultaneous done and error in the same WAIT cycle → rsp_error=1 and rsp_product=0.
- Reset mid-operation:
  - Drive RST_n=0 for 1 cycle during WAIT; next cycle all outputs are 0, busy=0 and no rsp_valid is issued.
  - A new req on requester 2 is then served first, since rr_ptr=0 and requesters 0 and 1 are idle.

Source files
------------

// File: rtl/fact_req_arbiter.sv
// Round-robin front end that shares one factorial accelerator between
// NREQ requesters, with a watchdog so a hung accelerator cannot stall them.
module fact_req_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_n,
   output logic [NREQ-1:0]   req_ack,
   output logic [3:0]        fa_n,
   output logic              fa_go,
   input  logic              fa_done,
   input  logic              fa_error,
   input  logic [31:0]       fa_product,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [31:0]       rsp_product,
   output logic              rsp_error,
   output logic              rsp_timeout,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t state;
   state_t state_nx;

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] rr_nx;
   logic [IDW-1:0] id;
   logic [IDW-1:0] win;
   logic [3:0]     win_n;
   logic           any;
   logic [TW-1:0]  timer;
   logic           expired;
   int             idx;

   logic [NREQ-1:0] ack_d;
   logic            go_d;
   logic [3:0]      n_d;
   logic            busy_d;
   logic            rv_d;
   logic [IDW-1:0]  rid_d;
   logic [31:0]     prod_d;
   logic            err_d;
   logic            to_d;

   // Scan starts at rr_ptr so the last served requester goes to the back.
   always_comb begin
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!any && req[idx]) begin
            any = 1'b1;
            win = IDW'(idx);
         end
      end
   end

   assign win_n   = req_n[4*int'(win) +: 4];
   assign expired = (timer == T_LAST);

   always_comb begin
      rr_nx = IDW'((int'(id) + 1) % NREQ);
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (any) state_nx = ISSUE;
         end
         ISSUE: begin
            state_nx = WAIT;
         end
         WAIT: begin
            if (fa_error || fa_done || expired) state_nx = RESP;
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Next values for the output registers; data fields hold by default.
   always_comb begin
      ack_d  = '0;
      go_d   = 1'b0;
      n_d    = fa_n;
      busy_d = (state_nx != IDLE);
      rv_d   = 1'b0;
      rid_d  = rsp_id;
      prod_d = rsp_product;
      err_d  = rsp_error;
      to_d   = rsp_timeout;
      if (state == IDLE && any) begin
         ack_d[win] = 1'b1;
         go_d       = 1'b1;
         n_d        = win_n;
      end
      if (state == WAIT && state_nx == RESP) begin
         rv_d  = 1'b1;
         rid_d = id;
         if (fa_error) begin
            prod_d = '0;
            err_d  = 1'b1;
            to_d   = 1'b0;
         end else if (fa_done) begin
            prod_d = fa_product;
            err_d  = 1'b0;
            to_d   = 1'b0;
         end else begin
            prod_d = '0;
            err_d  = 1'b1;
            to_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         rr_ptr      <= '0;
         timer       <= '0;
         id          <= '0;
         req_ack     <= '0;
         fa_go       <= 1'b0;
         fa_n        <= '0;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         req_ack     <= ack_d;
         fa_go       <= go_d;
         fa_n        <= n_d;
         busy        <= busy_d;
         rsp_valid   <= rv_d;
         rsp_id      <= rid_d;
         rsp_product <= prod_d;
         rsp_error   <= err_d;
         rsp_timeout <= to_d;
         if (state == IDLE && any) begin
            id <= win;
         end
         if (state == ISSUE) begin
            timer <= '0;
         end else if (state == WAIT) begin
            timer <= timer + 1'b1;
         end
         if (state == RESP) begin
            rr_ptr <= rr_nx;
         end
      end
   end

endmodule

// File: tb/tb_fact_req_arbiter.sv
// Randomized bench for fact_req_arbiter against a transaction-level model
// of round-robin order, factorial results, error and timeout responses.
module tb_fact_req_arbiter;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 64;

   logic              CLK = 1'b0;
   logic              RST_n;
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] req_n;
   logic [NREQ-1:0]   req_ack;
   logic [3:0]        fa_n;
   logic              fa_go;
   logic              fa_done = 1'b0;
   logic              fa_error = 1'b0;
   logic [31:0]       fa_product = '0;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [31:0]       rsp_product;
   logic              rsp_error;
   logic              rsp_timeout;
   logic              busy;

   fact_req_arbiter #(
      .NREQ   (NREQ),
      .IDW    (IDW),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .req        (req),
      .req_n      (req_n),
      .req_ack    (req_ack),
      .fa_n       (fa_n),
      .fa_go      (fa_go),
      .fa_done    (fa_done),
      .fa_error   (fa_error),
      .fa_product (fa_product),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_product(rsp_product),
      .rsp_error  (rsp_error),
      .rsp_timeout(rsp_timeout),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;

   // 0: normal, 1: never answers, 2: done and error together
   int         acc_mode = 0;
   int         acc_lat  = 1;
   int         acc_cnt  = 0;
   logic [3:0] acc_n    = '0;

   int          rr_model = 0;
   int          last_w   = 0;
   logic [31:0] last_prod;

   function automatic logic [31:0] fact(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 2; i <= n; i++) p = p * 32'(i);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Accelerator stub: clears on Go, answers acc_lat edges later.
   always @(posedge CLK) begin
      if (fa_go) begin
         acc_cnt  <= acc_lat;
         acc_n    <= fa_n;
         fa_done  <= 1'b0;
         fa_error <= 1'b0;
      end else if (acc_cnt > 0) begin
         acc_cnt <= acc_cnt - 1;
         if (acc_cnt == 1 && acc_mode != 1) begin
            if (acc_mode == 2) begin
               fa_done    <= 1'b1;
               fa_error   <= 1'b1;
               fa_product <= $urandom;
            end else if (acc_n > 4'd12) begin
               fa_error   <= 1'b1;
               fa_product <= $urandom;
            end else begin
               fa_done    <= 1'b1;
               fa_product <= fact(int'(acc_n));
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 32'({req_ack, fa_go, fa_n, rsp_valid, rsp_id,
                             rsp_error, rsp_timeout, busy}), 32'd0);
      chk({tag, "_prod"}, rsp_product, 32'd0);
   endtask

   // One full transaction starting from an IDLE cycle with req != 0.
   task automatic run_txn(input bit keep);
      int          w;
      int          cyc;
      bit          got;
      logic [3:0]  en;
      bit          e_err;
      bit          e_to;
      logic [31:0] e_prod;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (rr_model + k) % NREQ;
         if (w < 0 && req[i]) w = i;
      end
      en  = req_n[4*w +: 4];
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         got = (req_ack != '0);
      end
      chk("ack_seen", 32'(got), 32'd1);
      if (!got) return;
      chk("ack_id", 32'(req_ack), 32'd1 << w);
      chk("go", 32'(fa_go), 32'd1);
      chk("fa_n", 32'(fa_n), 32'(en));
      chk("busy", 32'(busy), 32'd1);
      if (!keep) req[w] = 1'b0;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < TIMEOUT + 20) begin
         tick();
         cyc++;
         got = rsp_valid;
      end
      chk("rsp_seen", 32'(got), 32'd1);
      if (!got) return;
      e_err  = (acc_mode != 0) || (en > 4'd12);
      e_to   = (acc_mode == 1);
      e_prod = e_err ? 32'd0 : fact(int'(en));
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_prod", rsp_product, e_prod);
      chk("rsp_err", 32'(rsp_error), 32'(e_err));
      chk("rsp_to", 32'(rsp_timeout), 32'(e_to));
      chk("rsp_lat", 32'(cyc), (acc_mode == 1) ? 32'(TIMEOUT + 1)
                                               : 32'(acc_lat + 2));
      chk("fa_n_hold", 32'(fa_n), 32'(en));
      last_prod = rsp_product;
      last_w    = w;
      rr_model  = (w + 1) % NREQ;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("rv_pulse", 32'(rsp_valid), 32'd0);
      chk("rsp_hold", 32'(rsp_id), 32'(w));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_ord[5];
      int exp_p[5];
      bit seen;
      logic [NREQ-1:0] nr;
      exp_ord = '{0, 1, 2, 3, 0};
      exp_p   = '{1, 2, 6, 24, 1};
      RST_n = 1'b0;
      req   = '0;
      req_n = '0;
      repeat (3) tick();
      check_zero("rst");
      RST_n = 1'b1;

      acc_mode = 0;
      acc_lat  = 2;
      req_n[3:0] = 4'd3;
      req = 4'b0001;
      run_txn(1'b0);
      chk("p3", last_prod, 32'd6);

      req_n[7:4] = 4'd12;
      req = 4'b0010;
      run_txn(1'b0);
      chk("p12", last_prod, 32'd479001600);

      acc_lat = 1;
      req_n[11:8] = 4'd13;
      req = 4'b0100;
      run_txn(1'b0);
      chk("p13", last_prod, 32'd0);

      acc_lat = 3;
      req_n[15:12] = 4'd0;
      req = 4'b1000;
      run_txn(1'b0);
      chk("p0", last_prod, 32'd1);

      acc_mode = 2;
      req_n[3:0] = 4'd6;
      req = 4'b0001;
      run_txn(1'b0);
      chk("both_prod", last_prod, 32'd0);

      acc_mode = 1;
      req_n[7:4] = 4'd4;
      req = 4'b0010;
      run_txn(1'b0);
      acc_mode = 0;
      req_n[11:8] = 4'd5;
      req = 4'b0100;
      run_txn(1'b0);
      chk("p5_after_to", last_prod, 32'd120);

      RST_n = 1'b0;
      tick();
      RST_n = 1'b1;
      rr_model = 0;
      acc_lat = 2;
      req_n = {4'd4, 4'd3, 4'd2, 4'd1};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         run_txn(1'b1);
         chk("fair_id", 32'(last_w), 32'(exp_ord[i]));
         chk("fair_p", last_prod, 32'(exp_p[i]));
      end
      req = '0;

      acc_mode = 1;
      req_n[3:0] = 4'd7;
      req = 4'b0001;
      tick();
      chk("mid_ack", 32'(req_ack), 32'd1);
      req = '0;
      repeat (5) tick();
      chk("mid_busy", 32'(busy), 32'd1);
      RST_n = 1'b0;
      tick();
      check_zero("mid");
      RST_n = 1'b1;
      rr_model = 0;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (rsp_valid || busy) seen = 1'b1;
      end
      chk("mid_quiet", 32'(seen), 32'd0);
      acc_mode = 0;
      req_n[11:8] = 4'd5;
      req = 4'b0100;
      run_txn(1'b0);
      chk("mid_id", 32'(last_w), 32'd2);
      chk("mid_p5", last_prod, 32'd120);

      for (int t = 0; t < 40; t++) begin
         nr = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            if (nr[i] && !req[i]) begin
               req_n[4*i +: 4] = 4'($urandom_range(0, 15));
               req[i] = 1'b1;
            end
         end
         case ($urandom_range(0, 9))
            0:       acc_mode = 1;
            1, 2:    acc_mode = 2;
            default: acc_mode = 0;
         endcase
         acc_lat = $urandom_range(1, 6);
         run_txn(1'($urandom_range(0, 1)));
      end
      req = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
